// File: rtl/ethernet_stats_pkg.sv
// Shared types and constants for the Ethernet receive statistics block.
package ethernet_stats_pkg;

  // One statistics counter per event flag in the per-frame vector.
  localparam int N_OF_ETHER_STATS_TYPE = 7;
  localparam int RD_ADDR_WIDTH         = 3;

  // Per-frame event flags from the MAC receive path, bit i feeds counter i.
  typedef logic [N_OF_ETHER_STATS_TYPE-1:0] ether_stats_vector;

  // Named counter indices (also the read addresses of each counter).
  typedef enum logic [RD_ADDR_WIDTH-1:0] {
    STAT_UNICAST     = 3'd0,
    STAT_MCAST       = 3'd1,
    STAT_BCAST       = 3'd2,
    STAT_OVERSIZED   = 3'd3,
    STAT_UNDERSIZED  = 3'd4,
    STAT_BAD_CRC     = 3'd5,
    STAT_VALID_FRAME = 3'd6
  } ether_stats_idx_e;

  // True when a read address selects an implemented counter.
  function automatic logic addr_in_range(input logic [RD_ADDR_WIDTH-1:0] addr);
    return int'(addr) < N_OF_ETHER_STATS_TYPE;
  endfunction

endpackage

// File: rtl/ethernet_stats_counter.sv
// One saturating statistics counter with a sticky saturation flag.
// Priority: rst / clr (clear_all) > rd_clr (clear-on-read) > inc.
module ethernet_stats_counter #(
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc,
  input  logic                     clr,
  input  logic                     rd_clr,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     sat
);

  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

  // Count qualified events, hold at the maximum and remember any lost increment.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (rst || clr) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (rd_clr) begin
      // The value just read is handed out; a coincident event starts the new tally.
      count <= COUNTER_WIDTH'(inc);
      sat   <= 1'b0;
    end else if (inc) begin
      if (count == COUNT_MAX) begin
        sat <= 1'b1;
      end else begin
        count <= count + COUNTER_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/ethernet_stats_counters.sv
// Bank of Ethernet receive statistics counters with a single-cycle read port.
module ethernet_stats_counters
  import ethernet_stats_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter bit CLEAR_ON_READ = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             stats_valid,
  input  ether_stats_vector                stats_vec,
  input  logic                             clear_all,
  input  logic                             rd_req,
  input  logic [RD_ADDR_WIDTH-1:0]         rd_addr,
  output logic                             rd_valid,
  output logic [COUNTER_WIDTH-1:0]         rd_data,
  output logic                             rd_err,
  output logic [N_OF_ETHER_STATS_TYPE-1:0] sat_flags
);

  logic [COUNTER_WIDTH-1:0]         counts [N_OF_ETHER_STATS_TYPE];
  logic [N_OF_ETHER_STATS_TYPE-1:0] inc_vec;
  logic [N_OF_ETHER_STATS_TYPE-1:0] rd_clr;
  logic [COUNTER_WIDTH-1:0]         rd_sel;
  logic                             addr_ok;

  assign inc_vec = stats_valid ? stats_vec : '0;
  assign addr_ok = addr_in_range(rd_addr);

  // Decode the read address into a value mux and per-counter clear-on-read strobes.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    rd_sel = '0;
    rd_clr = '0;
    for (int i = 0; i < N_OF_ETHER_STATS_TYPE; i++) begin
      if (rd_addr == RD_ADDR_WIDTH'(i)) begin
        rd_sel    = counts[i];
        rd_clr[i] = CLEAR_ON_READ && rd_req;
      end
    end
  end

  for (genvar g = 0; g < N_OF_ETHER_STATS_TYPE; g++) begin : g_counter
    ethernet_stats_counter #(
      .COUNTER_WIDTH(COUNTER_WIDTH)
    ) u_counter (
      .clk    (clk),
      .rst    (rst),
      .inc    (inc_vec[g]),
      .clr    (clear_all),
      .rd_clr (rd_clr[g]),
      .count  (counts[g]),
      .sat    (sat_flags[g])
    );
  end

  // Response register: captures the pre-edge counter value one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      rd_err   <= rd_req && !addr_ok;
      rd_data  <= (rd_req && addr_ok) ? rd_sel : '0;
    end
  end

endmodule

// File: tb/tb_ethernet_stats_counters.sv
// Bench for ethernet_stats_counters: three configurations driven by one stimulus
// stream and compared every cycle against an arithmetic reference model.
module tb_ethernet_stats_counters;
  import ethernet_stats_pkg::*;

  localparam int ND = 3; // 0: 32-bit, 1: 8-bit, 2: 8-bit clear-on-read
  localparam int NS = N_OF_ETHER_STATS_TYPE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stats_valid = 1'b0;
  ether_stats_vector stats_vec = '0;
  logic              clear_all = 1'b0;
  logic              rd_req = 1'b0;
  logic [2:0]        rd_addr = '0;

  logic          rd_valid_a, rd_err_a, rd_valid_b, rd_err_b, rd_valid_c, rd_err_c;
  logic [31:0]   rd_data_a;
  logic [7:0]    rd_data_b, rd_data_c;
  logic [NS-1:0] sat_a, sat_b, sat_c;

  int checks = 0;
  int errors = 0;
  string cur_test = "none";

  always #5 clk = ~clk;

  ethernet_stats_counters #(.COUNTER_WIDTH(32), .CLEAR_ON_READ(1'b0)) dut_a (
    .clk(clk), .rst(rst), .stats_valid(stats_valid), .stats_vec(stats_vec),
    .clear_all(clear_all), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_err(rd_err_a), .sat_flags(sat_a));

  ethernet_stats_counters #(.COUNTER_WIDTH(8), .CLEAR_ON_READ(1'b0)) dut_b (
    .clk(clk), .rst(rst), .stats_valid(stats_valid), .stats_vec(stats_vec),
    .clear_all(clear_all), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_err(rd_err_b), .sat_flags(sat_b));

  ethernet_stats_counters #(.COUNTER_WIDTH(8), .CLEAR_ON_READ(1'b1)) dut_c (
    .clk(clk), .rst(rst), .stats_valid(stats_valid), .stats_vec(stats_vec),
    .clear_all(clear_all), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_valid(rd_valid_c), .rd_data(rd_data_c), .rd_err(rd_err_c), .sat_flags(sat_c));

  // Observed outputs gathered per configuration.
  logic          obs_valid [ND];
  logic          obs_err   [ND];
  logic [31:0]   obs_data  [ND];
  logic [NS-1:0] obs_sat   [ND];
  assign obs_valid[0] = rd_valid_a;
  assign obs_valid[1] = rd_valid_b;
  assign obs_valid[2] = rd_valid_c;
  assign obs_err[0]   = rd_err_a;
  assign obs_err[1]   = rd_err_b;
  assign obs_err[2]   = rd_err_c;
  assign obs_data[0]  = rd_data_a;
  assign obs_data[1]  = {24'd0, rd_data_b};
  assign obs_data[2]  = {24'd0, rd_data_c};
  assign obs_sat[0]   = sat_a;
  assign obs_sat[1]   = sat_b;
  assign obs_sat[2]   = sat_c;

  // Reference model: plain event tallies capped at 2^W-1.
  longint unsigned m_max [ND] = '{64'hFFFF_FFFF, 64'd255, 64'd255};
  bit              m_cor [ND] = '{1'b0, 1'b0, 1'b1};
  longint unsigned m_cnt [ND][NS];
  bit              m_sat [ND][NS];
  bit              exp_valid [ND];
  bit              exp_err   [ND];
  longint unsigned exp_data  [ND];

  function automatic logic [NS-1:0] model_sat(input int d);
    logic [NS-1:0] v = '0;
    for (int i = 0; i < NS; i++) v[i] = m_sat[d][i];
    return v;
  endfunction

  // Apply the inputs present at this clock edge to the model.
  task automatic model_step();
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        exp_valid[d] = 0; exp_err[d] = 0; exp_data[d] = 0;
        for (int i = 0; i < NS; i++) begin m_cnt[d][i] = 0; m_sat[d][i] = 0; end
      end else begin
        exp_valid[d] = rd_req;
        exp_err[d]   = rd_req && (int'(rd_addr) >= NS);
        exp_data[d]  = (rd_req && int'(rd_addr) < NS) ? m_cnt[d][int'(rd_addr)] : 0;
        for (int i = 0; i < NS; i++) begin
          longint unsigned add = (stats_valid && stats_vec[i]) ? 1 : 0;
          if (clear_all) begin
            m_cnt[d][i] = 0; m_sat[d][i] = 0;
          end else if (m_cor[d] && rd_req && int'(rd_addr) == i) begin
            m_cnt[d][i] = add; m_sat[d][i] = 0;
          end else if (m_cnt[d][i] + add > m_max[d]) begin
            m_sat[d][i] = 1;
          end else begin
            m_cnt[d][i] = m_cnt[d][i] + add;
          end
        end
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model and score every configuration.
  task automatic tick(input bit r, input bit sv, input logic [NS-1:0] vec,
                      input bit ca, input bit rq, input logic [2:0] ad);
    rst = r; stats_valid = sv; stats_vec = vec; clear_all = ca; rd_req = rq; rd_addr = ad;
    @(posedge clk);
    model_step();
    #1;
    for (int d = 0; d < ND; d++) begin
      logic [33+NS:0] got, want;
      got  = {obs_valid[d], obs_err[d], obs_data[d], obs_sat[d]};
      want = {exp_valid[d], exp_err[d], exp_data[d][31:0], model_sat(d)};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL %s cfg%0d: got valid=%0b err=%0b data=%0d sat=%b, want valid=%0b err=%0b data=%0d sat=%b",
                 cur_test, d, obs_valid[d], obs_err[d], obs_data[d], obs_sat[d],
                 exp_valid[d], exp_err[d], exp_data[d], model_sat(d));
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, '0, 0, 0, 3'd0);
  endtask

  task automatic do_reset();
    tick(1, 0, '0, 0, 0, 3'd0);
    tick(1, 0, '0, 0, 0, 3'd0);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    do_reset();
    checks++;
    if ({rd_valid_a, rd_err_a, rd_data_a, sat_a, sat_b, sat_c} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b err=%0b data=%0d sat=%b, want all zero",
               rd_valid_a, rd_err_a, rd_data_a, sat_a);
    end
    for (int a = 0; a < NS; a++) tick(0, 0, '0, 0, 1, 3'(a));
  endtask

  task automatic test_basic();
    logic [31:0] want [3] = '{32'd5, 32'd5, 32'd0};
    logic [2:0]  addr [3] = '{3'd6, 3'd0, 3'd1};
    cur_test = "basic";
    do_reset();
    repeat (5) tick(0, 1, 7'b1000001, 0, 0, 3'd0);
    tick(0, 0, 7'b1111111, 0, 0, 3'd0); // vector ignored without stats_valid
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, '0, 0, 1, addr[k]);
      checks++;
      if (rd_data_a !== want[k]) begin
        errors++;
        $display("FAIL basic_addr%0d: got %0d, want %0d", addr[k], rd_data_a, want[k]);
      end
    end
  endtask

  task automatic test_saturation();
    cur_test = "saturation";
    do_reset();
    repeat (256) tick(0, 1, 7'b0000100, 0, 0, 3'd0);
    tick(0, 0, '0, 0, 1, 3'd2);
    checks++;
    if (rd_data_b !== 8'd255 || sat_b !== 7'b0000100) begin
      errors++;
      $display("FAIL sat_w8: got data=%0d sat=%b, want data=255 sat=0000100", rd_data_b, sat_b);
    end
    checks++;
    if (rd_data_a !== 32'd256 || sat_a !== '0) begin
      errors++;
      $display("FAIL sat_w32: got data=%0d sat=%b, want data=256 sat=0000000", rd_data_a, sat_a);
    end
    checks++;
    if (rd_data_c !== 8'd255 || sat_c !== '0) begin
      errors++;
      $display("FAIL sat_cor_read: got data=%0d sat=%b, want data=255 sat=0000000", rd_data_c, sat_c);
    end
    tick(0, 0, '0, 0, 1, 3'd2);
    checks++;
    if (rd_data_c !== 8'd0 || rd_data_b !== 8'd255) begin
      errors++;
      $display("FAIL sat_reread: got cor=%0d plain=%0d, want cor=0 plain=255", rd_data_c, rd_data_b);
    end
  endtask

  task automatic test_clear_on_read();
    cur_test = "clear_on_read";
    do_reset();
    repeat (3) tick(0, 1, 7'b0100000, 0, 0, 3'd0);
    tick(0, 1, 7'b0100000, 0, 1, 3'd5);
    checks++;
    if (rd_data_c !== 8'd3) begin
      errors++;
      $display("FAIL cor_first_read: got %0d, want 3", rd_data_c);
    end
    tick(0, 0, '0, 0, 1, 3'd5);
    checks++;
    if (rd_data_c !== 8'd1 || rd_data_a !== 32'd4) begin
      errors++;
      $display("FAIL cor_second_read: got cor=%0d plain=%0d, want cor=1 plain=4", rd_data_c, rd_data_a);
    end
  endtask

  task automatic test_bad_addr();
    cur_test = "bad_addr";
    do_reset();
    repeat (4) tick(0, 1, 7'($urandom), 0, 0, 3'd0);
    tick(0, 1, 7'b1111111, 0, 1, 3'd7);
    checks++;
    if ({rd_valid_a, rd_err_a, rd_data_a} !== {1'b1, 1'b1, 32'd0} ||
        {rd_valid_c, rd_err_c, rd_data_c} !== {1'b1, 1'b1, 8'd0}) begin
      errors++;
      $display("FAIL bad_addr_resp: got valid=%0b err=%0b data=%0d, want valid=1 err=1 data=0",
               rd_valid_a, rd_err_a, rd_data_a);
    end
    for (int a = 0; a < NS; a++) tick(0, 0, '0, 0, 1, 3'(a));
  endtask

  task automatic test_clear_all();
    cur_test = "clear_all";
    do_reset();
    repeat (9) tick(0, 1, 7'b0000001, 0, 0, 3'd0);
    tick(0, 1, 7'b1111111, 1, 1, 3'd0);
    checks++;
    if (rd_data_a !== 32'd9) begin
      errors++;
      $display("FAIL clear_all_read: got %0d, want 9", rd_data_a);
    end
    for (int a = 0; a < NS; a++) begin
      tick(0, 0, '0, 0, 1, 3'(a));
      checks++;
      if (rd_data_a !== 32'd0 || rd_data_c !== 8'd0) begin
        errors++;
        $display("FAIL clear_all_after%0d: got %0d, want 0", a, rd_data_a);
      end
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0;
    cur_test = "back_to_back";
    do_reset();
    repeat (10) tick(0, 1, 7'($urandom), 0, 0, 3'd0);
    for (int a = 0; a < NS; a++) begin
      tick(0, 0, '0, 0, 1, 3'(a));
      if (rd_valid_a === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== NS) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d, want %0d", pulses, NS);
    end
    for (int a = 0; a < 3; a++) tick(0, 1, 7'($urandom), 0, 1, 3'(a));
    tick(1, 1, 7'b1111111, 1, 1, 3'd3); // reset mid-stream, inputs must be ignored
    for (int k = 0; k < 3; k++) begin
      tick(0, 0, '0, 0, 0, 3'd0);
      checks++;
      if ({rd_valid_a, rd_valid_b, rd_valid_c} !== 3'b000) begin
        errors++;
        $display("FAIL b2b_after_rst%0d: got valid=%b, want 000", k,
                 {rd_valid_a, rd_valid_b, rd_valid_c});
      end
    end
  endtask

  task automatic test_random();
    cur_test = "random";
    do_reset();
    repeat (800) begin
      tick(($urandom_range(0, 199) == 0), 1'($urandom), 7'($urandom),
           ($urandom_range(0, 59) == 0), 1'($urandom), 3'($urandom));
    end
    for (int a = 0; a < 8; a++) tick(0, 0, '0, 0, 1, 3'(a));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_clear_on_read();
    test_bad_addr();
    test_clear_all();
    test_back_to_back();
    test_random();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
